// File: rtl/avalon_result_sink.sv
// Avalon-MM result sink: programmable waitrequest stalls, word buffer, 1-cycle read latency,
// sticky frame-done flag. Optional address checking under AVALON_SINK_ADDR_CHECK_EN.
module avalon_result_sink #(
   parameter int unsigned              ADDRESSWIDTH = 32,
   parameter int unsigned              DATAWIDTH    = 32,
   parameter int unsigned              DEPTH        = 512,
   parameter logic [ADDRESSWIDTH-1:0]  BASE_ADDR    = '0,
   parameter int unsigned              WAIT_CYCLES  = 3
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic [ADDRESSWIDTH-1:0]     slave_address,
   input  logic                        slave_write,
   input  logic [DATAWIDTH-1:0]        slave_writedata,
   input  logic                        slave_read,
   output logic [DATAWIDTH-1:0]        slave_readdata,
   output logic                        slave_readdatavalid,
   output logic                        slave_waitrequest,
   input  logic                        clear,
   output logic                        done,
`ifdef AVALON_SINK_ADDR_CHECK_EN
   output logic                        addr_error,
`endif
   output logic [$clog2(DEPTH):0]      write_count
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam logic [ADDRESSWIDTH-1:0] SPAN = ADDRESSWIDTH'(4 * DEPTH);
   localparam logic [3:0] WCNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {StIdle, StStall} state_t;

   state_t                    r_state;
   logic [3:0]                r_wcnt;
   logic [DATAWIDTH-1:0]      r_mem [DEPTH];
   logic [DATAWIDTH-1:0]      r_readdata;
   logic                      r_rdv;
   logic                      r_done;
   logic [CW-1:0]             r_write_count;

   logic                      w_req;
   logic                      w_wait;
   logic                      w_accept;
   logic [ADDRESSWIDTH-1:0]   w_off;
   logic                      w_in_range;
   logic [IW-1:0]             w_idx;
   logic                      w_wr_hit;
   logic                      w_rd_acc;
   logic [CW-1:0]             w_count_d;

   always_comb begin
      w_req      = slave_write | slave_read;
      w_off      = slave_address - BASE_ADDR;
      w_in_range = (slave_address >= BASE_ADDR) && (w_off < SPAN);
      w_idx      = w_off[IW+1:2];
   end

   always_comb begin
      w_wait   = 1'b0;
      w_accept = 1'b0;
      if (w_req) begin
         if (r_state == StIdle) begin
            if (WAIT_CYCLES == 0) w_accept = 1'b1;
            else                  w_wait   = 1'b1;
         end else begin
            if (r_wcnt == 4'd0) w_accept = 1'b1;
            else                w_wait   = 1'b1;
         end
      end
   end

   // Gated by reset so the stall drops immediately even while the master still holds its request.
   assign slave_waitrequest   = w_wait & n_rst;
   assign slave_readdata      = r_readdata;
   assign slave_readdatavalid = r_rdv;
   assign done                = r_done;
   assign write_count         = r_write_count;

   always_comb begin
      w_wr_hit  = w_accept & slave_write & w_in_range;
      w_rd_acc  = w_accept & slave_read & ~slave_write;
      w_count_d = r_write_count;
      if (clear)                                 w_count_d = w_wr_hit ? CW'(1) : '0;
      else if (w_wr_hit && r_write_count != FULL) w_count_d = r_write_count + CW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= StIdle;
         r_wcnt  <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_req && WAIT_CYCLES != 0) begin
                  r_wcnt  <= WCNT_LOAD;
                  r_state <= StStall;
               end
            end
            StStall: begin
               // A dropped request abandons the transfer.
               if (!w_req || r_wcnt == 4'd0) r_state <= StIdle;
               else                          r_wcnt  <= r_wcnt - 4'd1;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_hit) r_mem[w_idx] <= slave_writedata;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_readdata    <= '0;
         r_rdv         <= 1'b0;
         r_done        <= 1'b0;
         r_write_count <= '0;
      end else begin
         r_rdv         <= w_rd_acc;
         r_write_count <= w_count_d;
         r_done        <= clear ? 1'b0 : (r_done | (w_count_d == FULL));
         if (w_rd_acc) r_readdata <= w_in_range ? r_mem[w_idx] : '0;
      end
   end

`ifdef AVALON_SINK_ADDR_CHECK_EN
   logic r_addr_error;
   logic w_bad;

   assign w_bad      = w_accept & (~w_in_range | (slave_address[1:0] != 2'b00));
   assign addr_error = r_addr_error;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_addr_error <= 1'b0;
      else        r_addr_error <= (r_addr_error & ~clear) | w_bad;
   end
`endif

endmodule

// File: doc/avalon_result_sink.md
Name: avalon_result_sink

Overview:
Avalon-MM slave (responder) that terminates the FFT block's master port and captures the processed result words. It inserts programmable waitrequest stalls, stores accepted writes in an internal word buffer, and returns buffered words on reads with fixed one-cycle readdatavalid latency. A sticky done flag rises once a full frame of DEPTH words has been written, giving benches and system integration one reusable sink model/RTL for the master side.

Parameters:
ADDRESSWIDTH, 32, width of the byte address from the master.
DATAWIDTH, 32, data word width.
DEPTH, 512, buffer capacity in words; power of two.
BASE_ADDR, 32'h0000_0000, byte address of buffer word 0.
WAIT_CYCLES, 3, waitrequest-high cycles inserted before each transfer is accepted; 0 to 15.

Ports:
clk  in  1  system clock, rising edge.
n_rst  in  1  asynchronous active-low reset.
slave_address  in  ADDRESSWIDTH  byte address from the master.
slave_write  in  1  write request.
slave_writedata  in  DATAWIDTH  write data.
slave_read  in  1  read request.
slave_readdata  out  DATAWIDTH  read data; valid only with readdatavalid.
slave_readdatavalid  out  1  one-cycle strobe qualifying readdata.
slave_waitrequest  out  1  stall; the master holds its request and signals while this is high.
clear  in  1  synchronous pulse: zero write_count, drop done.
done  out  1  sticky; high once write_count reaches DEPTH.
write_count  out  log2(DEPTH)+1  number of accepted in-range writes since reset/clear.

Behaviour:
- Reset is asynchronous and active-low (n_rst). Reset values: waitrequest 0, readdatavalid 0, readdata 0, done 0, write_count 0, FSM IDLE, wait counter 0. Buffer contents are not reset.
- Word index: idx = (slave_address - BASE_ADDR) >> 2. The address is in range when BASE_ADDR <= address < BASE_ADDR + 4*DEPTH. Address bits [1:0] are ignored.
- FSM has two states, IDLE and STALL.
- IDLE, no request: waitrequest = 0.
- IDLE, request (read or write) with WAIT_CYCLES = 0: waitrequest = 0 combinationally and the transfer is accepted this cycle.
- IDLE, request with WAIT_CYCLES > 0: waitrequest = 1 combinationally; load wcnt = WAIT_CYCLES-1; go to STALL.
- STALL: waitrequest = 1 while wcnt != 0, and wcnt decrements. When wcnt = 0, waitrequest = 0, the transfer is accepted, and the FSM returns to IDLE.
- Stall timing: a held request sees exactly WAIT_CYCLES waitrequest-high cycles, then one accept cycle. Back-to-back requests each incur the full stall.
- Request dropped during STALL (protocol violation): return to IDLE, no transfer, no count change.
- Accepted write, in range: buf[idx] <= writedata; write_count increments. Out of range: data discarded, count unchanged.
- Accepted read: the cycle after accept, readdatavalid = 1 for exactly one cycle. readdata = buf[idx] if in range, else 0. Outside that strobe readdata is held at its last value.
- A read following a write to the same index returns the new data, because the write completes in the accept cycle.
- read and write asserted together: treated as a write; the read is ignored.
- done <= 1 when write_count reaches DEPTH. write_count saturates at DEPTH, and later writes still update the buffer.
- clear in the same cycle as an accepted in-range write: write_count ends at 1 and done = 0. clear has no effect on the FSM or the buffer.
- Reset asserted mid-stall or mid-read: outputs go to their reset values immediately and any pending readdatavalid is cancelled.

Optional Feature:
Macro AVALON_SINK_ADDR_CHECK_EN.
- When defined, adds output addr_error (1 bit, resets to 0). It is set sticky on any accepted transfer that is out of range or has address[1:0] != 0, and is cleared only by clear or reset.
- Misaligned in-range accesses still transfer using idx.
- When undefined, the port does not exist and no checking logic is built.

Test Plan:
- Reset, then hold a write to BASE_ADDR+0 of 32'hDEAD_BEEF with WAIT_CYCLES=3 -> waitrequest high for exactly 3 cycles, low on the 4th, write_count = 1.
- Write 512 words, data = index, at addresses 0..0x7FC -> done rises the cycle after the 512th accept and write_count = 512; a 513th write leaves write_count = 512.
- Write 32'h1234 to 0x010, then read 0x010 -> readdatavalid pulses one cycle after the read accept, with readdata = 32'h0000_1234; a read of 0x800 returns 0.
- Drop the request after 1 stall cycle, then pulse clear together with an accepted write -> no transfer from the dropped request; after the clear-plus-write cycle, write_count = 1 and done = 0.
- Assert n_rst low during STALL of a read -> waitrequest and readdatavalid are 0 immediately, and no readdatavalid appears after reset releases.
- With AVALON_SINK_ADDR_CHECK_EN defined, write to 0x003 -> addr_error = 1 and buf[0] is updated; clear drops addr_error to 0.
